// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_pkg                                                     |
// | Desc   : Shared frame-FSM state encoding and PS/2 prefix bytes.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // PS/2 frames carry odd parity over data plus parity bit.
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_code_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_code_fifo                                               |
// | Desc   : Power-of-two FIFO with occupancy count; push+pop at full ok.|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module ps2_code_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_FULL);
    assign count   = r_count;
    assign w_do_rd = rd_en & ~empty;
    // A write into a full FIFO is accepted only when a read frees the slot this cycle.
    assign w_do_wr = wr_en & (~full | w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_wr && !w_do_rd)
                r_count <= r_count + 1'b1;
            else if (w_do_rd && !w_do_wr)
                r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_rx_fifo                                                 |
// | Desc   : PS/2 receiver: sync, clock filter, frame FSM, prefix decode |
// |          and code FIFO. Define PS2_PARITY_CHECK_EN to reject frames  |
// |          with bad odd parity.                                        |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 4,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [9:0]               code_out,
    output logic                     code_valid,
    input  logic                     code_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     frame_err,
    output logic                     overflow
);
    localparam int             TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     c_FILT_LAST = 4'(FILT_LEN - 1);

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt, r_filt_d;
    logic [3:0]      r_filt_cnt;
    logic            w_fall;

    ps2_state_t      r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_good;
    logic [7:0]      r_byte;
    logic            r_expand, r_brk;
    logic            r_frame_err, r_overflow;
    logic            w_par_ok;

    logic            w_push, w_pop, w_full, w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_par <= 1'b0;
        else if (w_fall && r_state == ST_PARITY)
            r_par <= r_dat_s2;
    end
    assign w_par_ok = ps2_odd_parity_ok(r_shift, r_par);
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_good      <= 1'b0;
            r_byte      <= '0;
            r_expand    <= 1'b0;
            r_brk       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_good      <= 1'b0;
            r_frame_err <= 1'b0;

            // Prefix bytes only arm flags; any other good byte consumes them.
            if (r_good) begin
                if (r_byte == PS2_PFX_EXT) begin
                    r_expand <= 1'b1;
                end else if (r_byte == PS2_PFX_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_expand <= 1'b0;
                    r_brk    <= 1'b0;
                end
            end

            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
                if (w_fall && !r_dat_s2) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= '0;
                end
            end else if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: r_state <= ST_STOP;
                    default: begin
                        r_state <= ST_IDLE;
                        if (r_dat_s2 && w_par_ok) begin
                            r_good <= 1'b1;
                            r_byte <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_expand    <= 1'b0;
                            r_brk       <= 1'b0;
                        end
                    end
                endcase
            end else if (r_to_cnt == c_TO_LAST) begin
                r_state     <= ST_IDLE;
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
                r_expand    <= 1'b0;
                r_brk       <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign w_push = r_good && (r_byte != PS2_PFX_EXT) && (r_byte != PS2_PFX_BRK);
    assign w_pop  = ~w_empty & code_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overflow <= 1'b0;
        else
            r_overflow <= w_push & w_full & ~w_pop;
    end

    ps2_code_fifo #(
        .WIDTH (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data ({r_expand, r_brk, r_byte}),
        .rd_en   (code_ready),
        .rd_data (code_out),
        .count   (fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign code_valid = ~w_empty;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ps2_rx_fifo                                              |
// | Desc   : Directed bench for ps2_rx_fifo; honours PS2_PARITY_CHECK_EN.|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ps2_rx_fifo;
    localparam int FILT_LEN    = 4;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 8;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          code_ready = 1'b0;
    logic [9:0]    code_out;
    logic          code_valid;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overflow;

    int            errors = 0;
    int            checks = 0;
    int            n_ferr = 0;
    int            n_ovf  = 0;
    logic [9:0]    popped[$];

    ps2_rx_fifo #(
        .FILT_LEN    (FILT_LEN),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overflow === 1'b1) n_ovf++;
        if (code_valid === 1'b1 && code_ready === 1'b1) popped.push_back(code_out);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        repeat (4) tick();
        ps2_clk = 1'b0;
        repeat (HALF) tick();
        ps2_clk = 1'b1;
        repeat (HALF) tick();
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) tick();
            ps2_clk = 1'b1;
            repeat (HALF) tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop,
                              input int glitch_at, input int nbits);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ par_bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_at);
        if (nbits == 11) repeat (12) tick();
    endtask

    function automatic logic [9:0] pop_at(input int idx);
        return (popped.size() > idx) ? popped[idx] : 10'bx;
    endfunction

    task automatic test_reset;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", code_valid); end
        checks++; if (code_out !== 10'h000) begin errors++; $display("FAIL reset_code: got %h expected 000", code_out); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_basic;
        int q0, f0;
        q0 = popped.size(); f0 = n_ferr;
        code_ready = 1'b1;
        send_frame(8'h1C, 0, 1, -1, 11);
        checks++; if (popped.size() - q0 !== 1) begin errors++; $display("FAIL basic_beats: got %0d expected 1", popped.size() - q0); end
        checks++; if (pop_at(q0) !== 10'h01C) begin errors++; $display("FAIL basic_code: got %h expected 01c", pop_at(q0)); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL basic_ferr: got %0d expected 0", n_ferr - f0); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL basic_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_prefix;
        int q0;
        q0 = popped.size();
        send_frame(8'hE0, 0, 1, -1, 11);
        send_frame(8'hF0, 0, 1, -1, 11);
        send_frame(8'h75, 0, 1, -1, 11);
        send_frame(8'h1C, 0, 1, -1, 11);
        checks++; if (popped.size() - q0 !== 2) begin errors++; $display("FAIL prefix_beats: got %0d expected 2", popped.size() - q0); end
        checks++; if (pop_at(q0) !== 10'h375) begin errors++; $display("FAIL prefix_code: got %h expected 375", pop_at(q0)); end
        checks++; if (pop_at(q0 + 1) !== 10'h01C) begin errors++; $display("FAIL prefix_clear: got %h expected 01c", pop_at(q0 + 1)); end
    endtask

    task automatic test_overflow;
        int q0, o0;
        code_ready = 1'b0;
        o0 = n_ovf;
        for (int i = 0; i <= DEPTH; i++) send_frame(8'h11 + 8'(i), 0, 1, -1, 11);
        checks++; if (fifo_count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, DEPTH); end
        checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", n_ovf - o0); end
        checks++; if (code_out !== 10'h011) begin errors++; $display("FAIL ovf_head: got %h expected 011", code_out); end
        q0 = popped.size();
        code_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        checks++; if (popped.size() - q0 !== DEPTH) begin errors++; $display("FAIL ovf_drain_n: got %0d expected %0d", popped.size() - q0, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (pop_at(q0 + i) !== 10'h011 + 10'(i)) begin
                errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, pop_at(q0 + i), 10'h011 + 10'(i));
            end
        end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL ovf_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_bad_frame;
        int q0, f0;
        q0 = popped.size(); f0 = n_ferr;
        send_frame(8'h5B, 0, 0, -1, 11);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_ferr: got %0d expected 1", n_ferr - f0); end
        checks++; if (popped.size() - q0 !== 0) begin errors++; $display("FAIL stop_push: got %0d expected 0", popped.size() - q0); end

        q0 = popped.size(); f0 = n_ferr;
        send_frame(8'hE0, 0, 1, -1, 11);
        send_frame(8'h3C, 0, 0, -1, 11);
        send_frame(8'h75, 0, 1, -1, 11);
        checks++; if (pop_at(q0) !== 10'h075) begin errors++; $display("FAIL ferr_clears_flags: got %h expected 075", pop_at(q0)); end

        q0 = popped.size(); f0 = n_ferr;
        send_frame(8'h3C, 1, 1, -1, 11);
`ifdef PS2_PARITY_CHECK_EN
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL par_ferr: got %0d expected 1", n_ferr - f0); end
        checks++; if (popped.size() - q0 !== 0) begin errors++; $display("FAIL par_push: got %0d expected 0", popped.size() - q0); end
`else
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL par_ferr: got %0d expected 0", n_ferr - f0); end
        checks++; if (pop_at(q0) !== 10'h03C) begin errors++; $display("FAIL par_push: got %h expected 03c", pop_at(q0)); end
`endif
    endtask

    task automatic test_timeout;
        int q0, first, pulses;
        send_frame(8'h33, 0, 1, -1, 4);
        ps2_data = 1'b0;
        repeat (4) tick();
        ps2_clk = 1'b0;
        first = -1; pulses = 0;
        for (int k = 1; k <= TIMEOUT_CYC + 40; k++) begin
            tick();
            if (k == HALF) ps2_clk = 1'b1;
            if (frame_err === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++; if (first !== TIMEOUT_CYC + FILT_LEN + 3) begin errors++; $display("FAIL timeout_lat: got %0d expected %0d", first, TIMEOUT_CYC + FILT_LEN + 3); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", pulses); end
        q0 = popped.size();
        send_frame(8'h2A, 0, 1, -1, 11);
        checks++; if (pop_at(q0) !== 10'h02A) begin errors++; $display("FAIL timeout_recover: got %h expected 02a", pop_at(q0)); end
    endtask

    task automatic test_glitch;
        int q0, f0;
        q0 = popped.size(); f0 = n_ferr;
        send_frame(8'h5A, 0, 1, 4, 11);
        checks++; if (popped.size() - q0 !== 1) begin errors++; $display("FAIL glitch_beats: got %0d expected 1", popped.size() - q0); end
        checks++; if (pop_at(q0) !== 10'h05A) begin errors++; $display("FAIL glitch_code: got %h expected 05a", pop_at(q0)); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_reset_mid;
        int q0, f0;
        q0 = popped.size(); f0 = n_ferr;
        send_frame(8'h66, 0, 1, -1, 5);
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", code_valid); end
        checks++; if (code_out !== 10'h000) begin errors++; $display("FAIL rstmid_code: got %h expected 000", code_out); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        rst = 1'b0;
        repeat (TIMEOUT_CYC + 20) tick();
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rstmid_ferr: got %0d expected 0", n_ferr - f0); end
        checks++; if (popped.size() - q0 !== 0) begin errors++; $display("FAIL rstmid_push: got %0d expected 0", popped.size() - q0); end
        send_frame(8'h4D, 0, 1, -1, 11);
        checks++; if (pop_at(q0) !== 10'h04D) begin errors++; $display("FAIL rstmid_recover: got %h expected 04d", pop_at(q0)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_overflow();
        test_bad_frame();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
